// File: rtl/operator_scheduler.sv
// operator_scheduler: issues one VoiceOperatorID per clock to the synth
// pipeline, frames samples, handles start/stop with a pipeline flush, and
// funnels host configuration writes through a small FIFO onto a shared
// per-target write bus.
module operator_scheduler #(
  parameter int NUM_VOICE_OPERATORS = 128,
  parameter int ID_WIDTH            = $clog2(NUM_VOICE_OPERATORS),
  parameter int PIPELINE_DEPTH      = 12,
  parameter int FIFO_DEPTH          = 4,
  parameter int SYNC_CONFIG         = 1
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  input  logic                i_Enable,
  output logic [ID_WIDTH-1:0] o_VoiceOperator,
  output logic                o_OperatorValid,
  output logic                o_SampleStrobe,
  output logic                o_Halted,
  input  logic                i_CfgValid,
  output logic                o_CfgReady,
  input  logic [1:0]          i_CfgTarget,
  input  logic [ID_WIDTH-1:0] i_CfgAddr,
  input  logic [15:0]         i_CfgData,
  output logic                o_AlgorithmWriteEnable,
  output logic                o_PhaseStepWriteEnable,
  output logic                o_EnvelopeWriteEnable,
  output logic [ID_WIDTH-1:0] o_ConfigWriteAddr,
  output logic [15:0]         o_ConfigWriteData,
  output logic                o_CfgError
);

  localparam int FLUSH_W = $clog2(PIPELINE_DEPTH + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = 2 + ID_WIDTH + 16;

  localparam logic [ID_WIDTH-1:0] LAST_SLOT  = ID_WIDTH'(NUM_VOICE_OPERATORS - 1);
  localparam logic [FLUSH_W-1:0]  FLUSH_LAST = FLUSH_W'(PIPELINE_DEPTH);
  localparam logic [CNT_W-1:0]    FIFO_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_STOPPED,
    S_RUNNING,
    S_DRAINING,
    S_FLUSHING
  } state_t;

  state_t              r_State;
  state_t              w_NextState;
  logic [ID_WIDTH-1:0] r_Slot;
  logic [ID_WIDTH-1:0] w_NextSlot;
  logic [FLUSH_W-1:0]  r_Flush;
  logic [FLUSH_W-1:0]  w_NextFlush;
  logic                w_Issue;

  logic [ENTRY_W-1:0]  r_Mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_WrPtr;
  logic [PTR_W-1:0]    r_RdPtr;
  logic [CNT_W-1:0]    r_Count;
  logic [CNT_W-1:0]    w_NextCount;
  logic                w_Push;
  logic                w_Pop;
  logic                w_DrainAllowed;

  logic                r_RetValid;
  logic [ENTRY_W-1:0]  r_RetEntry;
  logic [1:0]          w_RetTarget;
  logic [ID_WIDTH-1:0] w_RetAddr;
  logic [15:0]         w_RetData;

  // Sequencer next-state logic: decides whether a slot is issued this edge,
  // and walks STOPPED -> RUNNING -> DRAINING -> FLUSHING. The slot counter
  // always rests at 0 in STOPPED because a sweep only ends after the last
  // slot, so the first issue of a run is slot 0. The flush counter stays in
  // FLUSHING until PIPELINE_DEPTH idle issue cycles have been presented.
  always_comb begin
    w_NextState = r_State;
    w_NextSlot  = r_Slot;
    w_NextFlush = r_Flush;
    w_Issue     = 1'b0;
    case (r_State)
      S_STOPPED: begin
        if (i_Enable) begin
          w_Issue     = 1'b1;
          w_NextSlot  = r_Slot + ID_WIDTH'(1);
          w_NextState = S_RUNNING;
        end
      end
      S_RUNNING, S_DRAINING: begin
        w_Issue    = 1'b1;
        w_NextSlot = r_Slot + ID_WIDTH'(1);
        if (i_Enable) begin
          w_NextState = S_RUNNING;
        end else if (r_Slot == LAST_SLOT) begin
          w_NextState = S_FLUSHING;
          w_NextFlush = '0;
        end else begin
          w_NextState = S_DRAINING;
        end
      end
      S_FLUSHING: begin
        if (r_Flush == FLUSH_LAST) begin
          w_NextState = S_STOPPED;
          w_NextFlush = '0;
        end else begin
          w_NextFlush = r_Flush + FLUSH_W'(1);
        end
      end
      default: begin
        w_NextState = S_STOPPED;
        w_NextFlush = '0;
      end
    endcase
  end

  // Sequencer state and registered issue outputs; the operator ID holds its
  // last value whenever nothing is issued.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State         <= S_STOPPED;
      r_Slot          <= '0;
      r_Flush         <= '0;
      o_VoiceOperator <= '0;
      o_OperatorValid <= 1'b0;
      o_SampleStrobe  <= 1'b0;
      o_Halted        <= 1'b1;
    end else begin
      r_State         <= w_NextState;
      r_Slot          <= w_NextSlot;
      r_Flush         <= w_NextFlush;
      o_OperatorValid <= w_Issue;
      o_SampleStrobe  <= w_Issue && (r_Slot == LAST_SLOT);
      o_Halted        <= (w_NextState == S_STOPPED);
      if (w_Issue) begin
        o_VoiceOperator <= r_Slot;
      end
    end
  end

  // FIFO handshake and occupancy. Draining looks at the current state, so a
  // retire decided in STOPPED still completes on the same edge that starts a
  // run, and stops immediately once RUNNING when writes must stay quiet.
  always_comb begin
    w_DrainAllowed = (SYNC_CONFIG == 0) || (r_State == S_STOPPED);
    w_Push         = i_CfgValid && o_CfgReady;
    w_Pop          = (r_Count != '0) && w_DrainAllowed;
    w_NextCount    = r_Count;
    case ({w_Push, w_Pop})
      2'b10:   w_NextCount = r_Count + CNT_W'(1);
      2'b01:   w_NextCount = r_Count - CNT_W'(1);
      default: w_NextCount = r_Count;
    endcase
  end

  // FIFO storage; contents need no reset because occupancy guards every read.
  always_ff @(posedge i_Clock) begin
    if (w_Push) begin
      r_Mem[r_WrPtr] <= {i_CfgTarget, i_CfgAddr, i_CfgData};
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_WrPtr    <= '0;
      r_RdPtr    <= '0;
      r_Count    <= '0;
      o_CfgReady <= 1'b1;
    end else begin
      r_Count    <= w_NextCount;
      o_CfgReady <= (w_NextCount != FIFO_FULL);
      if (w_Push) begin
        r_WrPtr <= r_WrPtr + PTR_W'(1);
      end
      if (w_Pop) begin
        r_RdPtr <= r_RdPtr + PTR_W'(1);
      end
    end
  end

  // Retire stage: the popped entry is captured here before being decoded.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_RetValid <= 1'b0;
      r_RetEntry <= '0;
    end else begin
      r_RetValid <= w_Pop;
      if (w_Pop) begin
        r_RetEntry <= r_Mem[r_RdPtr];
      end
    end
  end

  assign w_RetTarget = r_RetEntry[ENTRY_W-1 -: 2];
  assign w_RetAddr   = r_RetEntry[16 +: ID_WIDTH];
  assign w_RetData   = r_RetEntry[15:0];

  // Decode the retired entry into one write strobe (or an error pulse for
  // the reserved target); the shared bus only moves on real writes.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_AlgorithmWriteEnable <= 1'b0;
      o_PhaseStepWriteEnable <= 1'b0;
      o_EnvelopeWriteEnable  <= 1'b0;
      o_CfgError             <= 1'b0;
      o_ConfigWriteAddr      <= '0;
      o_ConfigWriteData      <= '0;
    end else begin
      o_AlgorithmWriteEnable <= r_RetValid && (w_RetTarget == 2'd0);
      o_PhaseStepWriteEnable <= r_RetValid && (w_RetTarget == 2'd1);
      o_EnvelopeWriteEnable  <= r_RetValid && (w_RetTarget == 2'd2);
      o_CfgError             <= r_RetValid && (w_RetTarget == 2'd3);
      if (r_RetValid && (w_RetTarget != 2'd3)) begin
        o_ConfigWriteAddr <= w_RetAddr;
        o_ConfigWriteData <= w_RetData;
      end
    end
  end

endmodule

// File: doc/operator_scheduler.md
Name: operator_scheduler

Overview:
- Top-level sequencer for the voice/operator pipeline: generates one VoiceOperatorID per clock to feed stage_modulator and downstream stages, frames samples, and handles start/stop with pipeline flush.
- Owns the single configuration write path: buffers host register writes in a small FIFO and retires them one per clock as per-target write enables with a shared address/data bus. Sits between the host register interface and the synth pipeline.

Parameters:
- NUM_VOICE_OPERATORS, 128, operator slots per sample (16 voices × 8 operators); must be a power of two.
- ID_WIDTH, $clog2(NUM_VOICE_OPERATORS), VoiceOperatorID width (7).
- PIPELINE_DEPTH, 12, cycles from o_VoiceOperator issue to last pipeline stage output; flush length.
- FIFO_DEPTH, 4, config write FIFO entries; power of two, ≥2.
- SYNC_CONFIG, 1, 1 = retire config writes only in STOPPED; 0 = retire in any state.

Ports:
- i_Clock, in, 1, clock.
- i_Reset, in, 1, synchronous, active-high reset.
- i_Enable, in, 1, level: 1 = run, 0 = stop at next sample boundary.
- o_VoiceOperator, out, ID_WIDTH, operator slot issued this cycle.
- o_OperatorValid, out, 1, o_VoiceOperator is a live issue.
- o_SampleStrobe, out, 1, one-cycle pulse coincident with issue of slot NUM_VOICE_OPERATORS-1.
- o_Halted, out, 1, STOPPED state and pipeline empty.
- i_CfgValid, in, 1, host write request.
- o_CfgReady, out, 1, FIFO can accept; a write is taken when valid & ready.
- i_CfgTarget, in, 2, 0 = algorithm, 1 = phase step, 2 = envelope, 3 = reserved.
- i_CfgAddr, in, ID_WIDTH, target operator slot.
- i_CfgData, in, 16, write data.
- o_AlgorithmWriteEnable, out, 1, write strobe to stage_modulator.
- o_PhaseStepWriteEnable, out, 1, write strobe to phase stage.
- o_EnvelopeWriteEnable, out, 1, write strobe to envelope stage.
- o_ConfigWriteAddr, out, ID_WIDTH, retired write address.
- o_ConfigWriteData, out, 16, retired write data.
- o_CfgError, out, 1, one-cycle pulse when a target-3 entry is retired (discarded).

Behaviour:
- Reset (synchronous, i_Reset high at edge): state STOPPED, slot counter 0, flush counter 0, FIFO empty.
- Outputs during/after reset: o_VoiceOperator=0, o_OperatorValid=0, o_SampleStrobe=0, all write enables=0, o_CfgError=0, o_ConfigWriteAddr=0, o_ConfigWriteData=0, o_CfgReady=1, o_Halted=1.
- Reset mid-operation abandons the sweep and drops all FIFO contents.
- All outputs are registered.
- State machine:
  - STOPPED -> RUNNING when i_Enable=1. First issue is slot 0 in the cycle after the transition edge.
  - RUNNING: issues slot counter value with o_OperatorValid=1, then increments and wraps NUM_VOICE_OPERATORS-1 -> 0. If i_Enable=0, moves to DRAINING; slot order is unaffected.
  - DRAINING: keeps issuing until slot NUM_VOICE_OPERATORS-1 is issued, then enters FLUSHING. If i_Enable returns to 1 during DRAINING, goes back to RUNNING with no gap. A sweep is never truncated.
  - FLUSHING: o_OperatorValid=0, and the counter runs PIPELINE_DEPTH cycles. i_Enable is ignored. Then STOPPED.
  - o_Halted=1 only in STOPPED.
- o_SampleStrobe=1 exactly when slot NUM_VOICE_OPERATORS-1 is issued with valid. Never outside RUNNING/DRAINING.
- o_VoiceOperator holds its last value while o_OperatorValid=0.
- Config FIFO:
  - o_CfgReady = not full.
  - Push on i_CfgValid & o_CfgReady.
  - Pop one entry per cycle when non-empty and (SYNC_CONFIG=0 or state=STOPPED).
  - Simultaneous push and pop when full is not permitted, because ready is low.
  - Simultaneous push and pop when non-full: occupancy unchanged, and order is preserved.
  - Write to empty FIFO with drain allowed: strobe appears 2 cycles after the accepting edge (push, then pop, then registered output).
- Retire: exactly one of the three write enables pulses for one cycle per popped entry, decoded from target. Addr/data update on that cycle and hold afterwards. Target 3 raises o_CfgError instead of a write enable.
- SYNC_CONFIG=1 with FIFO non-empty at STOPPED->RUNNING: draining stops immediately; remaining entries wait for the next STOPPED.
- Enable assertion and retire in the same cycle: the retire completes in that cycle (STOPPED evaluated before transition).

Test Plan:
- Reset, i_Enable=1 for 300 cycles -> valid issues 0..127, 0..127, ... with no gaps; o_SampleStrobe high exactly on each slot-127 issue; o_Halted=0 from the first run cycle.
- Running at slot 40, drop i_Enable -> issues continue to slot 127, then 12 cycles valid=0, then o_Halted=1; re-raise i_Enable at slot 100 in a second run -> no stop, no gap.
- SYNC_CONFIG=1, stopped: push (target 0, addr 5, data 0x07FF) -> o_AlgorithmWriteEnable one cycle, addr 5, data 0x07FF, 2 cycles after the push edge.
- SYNC_CONFIG=1, running: push 5 writes back-to-back -> 4 accepted, ready low on the 5th until stop; all 4 retire in order on consecutive cycles once STOPPED, then the 5th.
- Target 3 write, addr 9 -> o_CfgError pulse, no write enable; targets 1 and 2 -> correct single enable.
- Assert i_Reset at slot 60 with 3 FIFO entries -> next cycle valid=0, o_Halted=1, FIFO empty, no write enables ever issued for the dropped entries.
